// File: rtl/mips_pipe_stage.sv
// Pipeline stage register with valid/ready handshake, flush and an optional
// two-entry skid buffer enabled by defining PIPE_STAGE_SKID_EN.
module mips_pipe_stage #(
  parameter int unsigned DW             = 32,
  parameter bit          CLEAR_ON_FLUSH = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [DW-1:0] up_data,
  output logic          dn_valid,
  input  logic          dn_ready,
  output logic [DW-1:0] dn_data,
  output logic [1:0]    occupancy
);

  logic [DW-1:0] main_q, main_d;
  logic          dn_valid_q, dn_valid_d;

`ifdef PIPE_STAGE_SKID_EN
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] skid_q, skid_d;
  logic          up_ready_q, up_ready_d;
  logic [1:0]    occ_q, occ_d;

  // State, payload and registered status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      dn_valid_q <= 1'b0;
      up_ready_q <= 1'b1;
      occ_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      dn_valid_q <= dn_valid_d;
      up_ready_q <= up_ready_d;
      occ_q      <= occ_d;
    end
  end

  // Next state and payload moves; flush overrides any handshake
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      if (CLEAR_ON_FLUSH) begin
        main_d = '0;
        skid_d = '0;
      end else begin
        main_d = main_q;
        skid_d = skid_q;
      end
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (up_valid) begin
            main_d  = up_data;
            state_d = ST_ONE;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (dn_ready && up_valid) begin
            main_d  = up_data;
            state_d = ST_ONE;
          end else if (dn_ready) begin
            state_d = ST_EMPTY;
          end else if (up_valid) begin
            skid_d  = up_data;
            state_d = ST_FULL;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_FULL: begin
          if (dn_ready) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end else begin
            state_d = ST_FULL;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Status flags are precomputed from the next state so they leave as flops
  always_comb begin
    dn_valid_d = (state_d != ST_EMPTY);
    up_ready_d = (state_d != ST_FULL);
    case (state_d)
      ST_EMPTY: occ_d = 2'd0;
      ST_ONE:   occ_d = 2'd1;
      ST_FULL:  occ_d = 2'd2;
      default:  occ_d = 2'd0;
    endcase
  end

  assign up_ready  = up_ready_q;
  assign occupancy = occ_q;
`else
  logic accept_s;

  assign up_ready  = !dn_valid_q || dn_ready;
  assign accept_s  = up_valid && up_ready;
  assign occupancy = {1'b0, dn_valid_q};

  // Single main register
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q     <= '0;
      dn_valid_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      dn_valid_q <= dn_valid_d;
    end
  end

  // Load on accept, drop valid on drain; flush discards the offered beat
  always_comb begin
    main_d     = main_q;
    dn_valid_d = dn_valid_q;
    if (flush) begin
      dn_valid_d = 1'b0;
      if (CLEAR_ON_FLUSH) begin
        main_d = '0;
      end else begin
        main_d = main_q;
      end
    end else if (accept_s) begin
      main_d     = up_data;
      dn_valid_d = 1'b1;
    end else if (dn_ready) begin
      dn_valid_d = 1'b0;
    end else begin
      dn_valid_d = dn_valid_q;
    end
  end
`endif

  assign dn_valid = dn_valid_q;
  assign dn_data  = main_q;

endmodule

// File: tb/tb_mips_pipe_stage.sv
// Directed self-checking bench for mips_pipe_stage; follows PIPE_STAGE_SKID_EN.
module tb_mips_pipe_stage;

  logic        clk = 1'b0;
  logic        rst, flush, up_valid, dn_ready;
  logic [31:0] up_data;
  logic        up_ready, dn_valid, up_ready_nc, dn_valid_nc;
  logic [31:0] dn_data, dn_data_nc;
  logic [1:0]  occupancy, occupancy_nc;
  int          pass_cnt = 0;
  int          check_cnt = 0;

  always #5 clk = ~clk;

  mips_pipe_stage #(.DW(32), .CLEAR_ON_FLUSH(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .up_valid(up_valid), .up_ready(up_ready),
    .up_data(up_data), .dn_valid(dn_valid), .dn_ready(dn_ready), .dn_data(dn_data),
    .occupancy(occupancy));

  mips_pipe_stage #(.DW(32), .CLEAR_ON_FLUSH(1'b0)) dut_nc (
    .clk(clk), .rst(rst), .flush(flush), .up_valid(up_valid), .up_ready(up_ready_nc),
    .up_data(up_data), .dn_valid(dn_valid_nc), .dn_ready(dn_ready), .dn_data(dn_data_nc),
    .occupancy(occupancy_nc));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; up_valid = 1'b1; up_data = 32'hDEAD; dn_ready = 1'b0;
    tick();
    tick();
    check_cnt++; if (dn_valid !== 1'b0) $display("FAIL rst_dn_valid got %0b exp 0", dn_valid); else pass_cnt++;
    check_cnt++; if (dn_data !== 32'h0) $display("FAIL rst_dn_data got %h exp 0", dn_data); else pass_cnt++;
    check_cnt++; if (occupancy !== 2'd0) $display("FAIL rst_occ got %0d exp 0", occupancy); else pass_cnt++;
    check_cnt++; if (up_ready !== 1'b1) $display("FAIL rst_up_ready got %0b exp 1", up_ready); else pass_cnt++;
    check_cnt++; if (dn_data_nc !== 32'h0) $display("FAIL rst_nc_data got %h exp 0", dn_data_nc); else pass_cnt++;
    rst = 1'b0; up_valid = 1'b0;
    tick();
    check_cnt++; if (dn_valid !== 1'b0) $display("FAIL post_rst_dn_valid got %0b exp 0", dn_valid); else pass_cnt++;
    check_cnt++; if (up_ready !== 1'b1) $display("FAIL post_rst_up_ready got %0b exp 1", up_ready); else pass_cnt++;
    check_cnt++; if (occupancy !== 2'd0) $display("FAIL post_rst_occ got %0d exp 0", occupancy); else pass_cnt++;
  endtask

  task automatic test_stream();
    logic [31:0] vals [3];
    vals[0] = 32'h1; vals[1] = 32'h2; vals[2] = 32'h3;
    dn_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      up_valid = 1'b1; up_data = vals[i];
      tick();
      check_cnt++; if (dn_valid !== 1'b1) $display("FAIL stream_valid[%0d] got %0b exp 1", i, dn_valid); else pass_cnt++;
      check_cnt++; if (dn_data !== vals[i]) $display("FAIL stream_data[%0d] got %h exp %h", i, dn_data, vals[i]); else pass_cnt++;
      check_cnt++; if (occupancy !== 2'd1) $display("FAIL stream_occ[%0d] got %0d exp 1", i, occupancy); else pass_cnt++;
    end
    up_valid = 1'b0;
    tick();
    check_cnt++; if (dn_valid !== 1'b0) $display("FAIL drain_valid got %0b exp 0", dn_valid); else pass_cnt++;
    check_cnt++; if (dn_data !== 32'h3) $display("FAIL drain_data_kept got %h exp 3", dn_data); else pass_cnt++;
    check_cnt++; if (occupancy !== 2'd0) $display("FAIL drain_occ got %0d exp 0", occupancy); else pass_cnt++;
    dn_ready = 1'b0;
  endtask

`ifdef PIPE_STAGE_SKID_EN
  task automatic test_backpressure();
    dn_ready = 1'b0; up_valid = 1'b1; up_data = 32'hA;
    tick();
    check_cnt++; if (occupancy !== 2'd1) $display("FAIL skid_occ1 got %0d exp 1", occupancy); else pass_cnt++;
    check_cnt++; if (up_ready !== 1'b1) $display("FAIL skid_rdy1 got %0b exp 1", up_ready); else pass_cnt++;
    up_data = 32'hB;
    tick();
    check_cnt++; if (occupancy !== 2'd2) $display("FAIL skid_occ2 got %0d exp 2", occupancy); else pass_cnt++;
    check_cnt++; if (up_ready !== 1'b0) $display("FAIL skid_rdy_full got %0b exp 0", up_ready); else pass_cnt++;
    check_cnt++; if (dn_data !== 32'hA) $display("FAIL skid_head got %h exp a", dn_data); else pass_cnt++;
    up_data = 32'hE;
    tick();
    check_cnt++; if (occupancy !== 2'd2) $display("FAIL full_ignore_occ got %0d exp 2", occupancy); else pass_cnt++;
    up_valid = 1'b0; dn_ready = 1'b1;
    #1;
    check_cnt++; if (dn_data !== 32'hA) $display("FAIL drain_first got %h exp a", dn_data); else pass_cnt++;
    check_cnt++; if (up_ready !== 1'b0) $display("FAIL full_rdy_no_comb got %0b exp 0", up_ready); else pass_cnt++;
    tick();
    check_cnt++; if (dn_data !== 32'hB) $display("FAIL drain_second got %h exp b", dn_data); else pass_cnt++;
    check_cnt++; if (up_ready !== 1'b1) $display("FAIL drain_rdy got %0b exp 1", up_ready); else pass_cnt++;
    check_cnt++; if (occupancy !== 2'd1) $display("FAIL drain_occ1 got %0d exp 1", occupancy); else pass_cnt++;
    tick();
    check_cnt++; if (dn_valid !== 1'b0) $display("FAIL drain_empty got %0b exp 0", dn_valid); else pass_cnt++;
    dn_ready = 1'b0;
  endtask
`else
  task automatic test_backpressure();
    dn_ready = 1'b0; up_valid = 1'b1; up_data = 32'h10;
    tick();
    up_valid = 1'b0;
    #1;
    check_cnt++; if (dn_valid !== 1'b1) $display("FAIL bp_valid got %0b exp 1", dn_valid); else pass_cnt++;
    check_cnt++; if (up_ready !== 1'b0) $display("FAIL bp_rdy_low got %0b exp 0", up_ready); else pass_cnt++;
    tick();
    check_cnt++; if (dn_data !== 32'h10) $display("FAIL bp_hold got %h exp 10", dn_data); else pass_cnt++;
    dn_ready = 1'b1;
    #1;
    check_cnt++; if (up_ready !== 1'b1) $display("FAIL bp_rdy_comb got %0b exp 1", up_ready); else pass_cnt++;
    up_valid = 1'b1; up_data = 32'h11;
    tick();
    check_cnt++; if (dn_data !== 32'h11) $display("FAIL pushpop_data got %h exp 11", dn_data); else pass_cnt++;
    check_cnt++; if (occupancy !== 2'd1) $display("FAIL pushpop_occ got %0d exp 1", occupancy); else pass_cnt++;
    up_valid = 1'b0;
    tick();
    check_cnt++; if (dn_valid !== 1'b0) $display("FAIL bp_empty got %0b exp 0", dn_valid); else pass_cnt++;
    dn_ready = 1'b0;
  endtask
`endif

  task automatic test_flush();
    logic [1:0] occ_exp;
    dn_ready = 1'b0; up_valid = 1'b1; up_data = 32'h55;
    tick();
`ifdef PIPE_STAGE_SKID_EN
    up_data = 32'hB;
    tick();
    occ_exp = 2'd2;
`else
    occ_exp = 2'd1;
`endif
    check_cnt++; if (occupancy !== occ_exp) $display("FAIL pre_flush_occ got %0d exp %0d", occupancy, occ_exp); else pass_cnt++;
    flush = 1'b1; up_valid = 1'b1; up_data = 32'hC;
    tick();
    flush = 1'b0; up_valid = 1'b0;
    #1;
    check_cnt++; if (dn_valid !== 1'b0) $display("FAIL flush_valid got %0b exp 0", dn_valid); else pass_cnt++;
    check_cnt++; if (occupancy !== 2'd0) $display("FAIL flush_occ got %0d exp 0", occupancy); else pass_cnt++;
    check_cnt++; if (dn_data !== 32'h0) $display("FAIL flush_clear got %h exp 0", dn_data); else pass_cnt++;
    check_cnt++; if (up_ready !== 1'b1) $display("FAIL flush_rdy got %0b exp 1", up_ready); else pass_cnt++;
    check_cnt++; if (dn_valid_nc !== 1'b0) $display("FAIL flush_nc_valid got %0b exp 0", dn_valid_nc); else pass_cnt++;
    check_cnt++; if (dn_data_nc !== 32'h55) $display("FAIL flush_nc_hold got %h exp 55", dn_data_nc); else pass_cnt++;
    tick();
    check_cnt++; if (dn_valid !== 1'b0) $display("FAIL flush_no_c got %0b exp 0", dn_valid); else pass_cnt++;
    check_cnt++; if (dn_data_nc !== 32'h55) $display("FAIL flush_nc_no_c got %h exp 55", dn_data_nc); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/mips_pipe_stage.md
# mips_pipe_stage

Parametrised pipeline stage register with valid/ready handshake, flush and an optional two-entry skid buffer. It generalises the fixed-field stall/flush stage registers to an arbitrary-width payload. It decouples producer and consumer back-pressure so ready does not propagate combinationally through the pipe. It sits between any two core stages (ID/EX, EX/MEM, MEM/WB); the stage's fields are packed into one payload vector.

## Interface
- DW, 32, payload width in bits (≥1)
- CLEAR_ON_FLUSH, 1, 1: payload registers zeroed on flush; 0: only valid state cleared, payload holds
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all buffered entries and any beat offered this cycle
- up_valid  in  1  producer offers up_data
- up_ready  out  1  stage accepts a beat this cycle
- up_data  in  DW  producer payload
- dn_valid  out  1  dn_data holds a valid entry
- dn_ready  in  1  consumer takes dn_data this cycle
- dn_data  out  DW  head entry payload
- occupancy  out  2  number of valid entries held (0..2)

## Operation
- Beat accepted upstream iff up_valid && up_ready at the clock edge; delivered downstream iff dn_valid && dn_ready.
- Storage: main register (drives dn_data, dn_valid) plus skid register (only with skid enabled).
- States (skid enabled): EMPTY (occ 0), ONE (occ 1), FULL (occ 2).
  - EMPTY: up_valid -> main<=up_data, ONE; else stay. dn_ready ignored.
  - ONE: dn_ready & up_valid -> main<=up_data, ONE; dn_ready & !up_valid -> EMPTY; !dn_ready & up_valid -> skid<=up_data, FULL; neither -> hold.
  - FULL: up_ready=0, up_valid ignored; dn_ready -> main<=skid, ONE; else hold.
- Ordering strictly FIFO; no beat duplicated or dropped except by flush/rst.
- On leaving ONE->EMPTY, dn_data keeps its last value (dn_valid=0).
- Flush (any state): next state EMPTY, dn_valid=0, occupancy=0, up_ready=1; beat offered same cycle is not accepted (up_ready still reported per current state, but beat discarded). dn_ready handshake in the flush cycle counts as delivered. CLEAR_ON_FLUSH=1 zeroes main and skid payloads.
- Priority: rst > flush > handshake updates.

## Timing
- Reset values: dn_valid=0, dn_data=0, occupancy=0, up_ready=1 (skid enabled) / up_ready=1 via combinational term (skid disabled); skid payload=0.
- Latency: accepted beat appears on dn_data/dn_valid the following cycle (1 cycle), from EMPTY or ONE-with-drain.
- Skid enabled: up_ready is a register output (= state != FULL), no combinational path dn_ready->up_ready. Full throughput 1 beat/cycle when dn_ready held high.
- Back-pressure: after dn_ready drops, up to one further beat accepted (into skid); up_ready low from the next cycle.
- Reset or flush mid-stream: takes effect at that edge; no partial entry survives.

## Configuration
- PIPE_STAGE_SKID_EN defined: two-entry skid buffer, registered up_ready, occupancy 0..2, states as above.
- Not defined: single main register only; up_ready = !dn_valid || dn_ready (combinational); FULL unreachable, occupancy 0..1; skid register absent. Flush/reset behaviour identical.

## Test plan
- Reset: assert rst 2 cycles with up_valid=1, up_data=0xDEAD -> dn_valid=0, dn_data=0, occupancy=0, up_ready=1 during and after reset.
- Streaming: dn_ready=1, push 0x1,0x2,0x3 back-to-back -> dn_data 0x1,0x2,0x3 on the three consecutive cycles after each accept, occupancy stays 1.
- Skid (SKID_EN): main holds 0xA, dn_ready=0, push 0xB -> occupancy=2, up_ready=0 next cycle; raise dn_ready -> 0xA then 0xB delivered, up_ready returns to 1 after first drain.
- Flush in FULL: entries 0xA,0xB held, flush=1 with up_valid=1/up_data=0xC -> next cycle dn_valid=0, occupancy=0, dn_data=0 (CLEAR_ON_FLUSH=1); 0xC never appears.
- CLEAR_ON_FLUSH=0: flush with main=0x55 -> dn_valid=0, dn_data stays 0x55.
- No-skid build: dn_ready=0, dn_valid=1 -> up_ready=0 same cycle; dn_ready=1 -> up_ready=1 same cycle, simultaneous push/pop keeps occupancy=1.
